// File: rtl/fp32_pkg.sv
// -----------------------------------------------------------------------------
// fp32_pkg
// Shared types and constants for the fp32 adder result buffer.
//   fp32_flags_t : adder exception flags {invalid, overflow, underflow}
//   fp32_entry_t : one buffered result {result[31:0], flags}
//   FP32_QNAN    : canonical quiet NaN pattern
//   STICKY_*     : bit positions inside the 4-bit sticky status vector
// -----------------------------------------------------------------------------
package fp32_pkg;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp32_flags_t;

  typedef struct packed {
    logic [31:0] result;
    fp32_flags_t flags;
  } fp32_entry_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  localparam int STICKY_W         = 4;
  localparam int STICKY_LOST      = 3;
  localparam int STICKY_INVALID   = 2;
  localparam int STICKY_OVERFLOW  = 1;
  localparam int STICKY_UNDERFLOW = 0;

  // True for any NaN encoding: all-ones exponent with a non-zero mantissa.
  function automatic logic fp32_is_nan(input logic [31:0] value);
    return (value[30:23] == 8'hFF) && (value[22:0] != 23'd0);
  endfunction

  // Replace any NaN payload with the canonical quiet NaN; other values pass.
  function automatic logic [31:0] fp32_canon_nan(input logic [31:0] value);
    logic [31:0] canon;
    if (fp32_is_nan(value)) begin
      canon = FP32_QNAN;
    end else begin
      canon = value;
    end
    return canon;
  endfunction

endpackage

// File: rtl/fp32_resbuf_fifo.sv
// -----------------------------------------------------------------------------
// fp32_resbuf_fifo
// Generic synchronous FIFO of fp32_entry_t. Full/empty are derived from the
// occupancy counter; pointers are log2(DEPTH) bits and wrap naturally, so
// DEPTH must be a power of two. A push while full is accepted only when a
// pop happens in the same cycle. No bypass: a pushed entry becomes visible
// at the head one cycle later.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, wdata_i  : write request and entry
//   pop_i            : remove head (ignored while empty)
//   rdata_o          : head entry (read from the storage registers)
//   full_o, empty_o  : occupancy status
//   count_o          : current occupancy
// -----------------------------------------------------------------------------
module fp32_resbuf_fifo
  import fp32_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  fp32_entry_t                wdata_i,
  input  logic                       pop_i,
  output fp32_entry_t                rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_EMPTY = {CNT_W{1'b0}};

  fp32_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == CNT_EMPTY);
  assign pop_ok_s  = pop_i && !empty_s;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_s = push_i && (!full_s || pop_ok_s);

  // Storage and pointer registers; storage is cleared so the head reads zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata_i;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= CNT_EMPTY;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_r;

endmodule

// File: rtl/fp32_add_result_buffer.sv
// -----------------------------------------------------------------------------
// fp32_add_result_buffer
// Captures every fp32Adder result (with exception flags) into a FIFO and
// hands it to a consumer over valid/ready. The adder cannot be stalled, so an
// issue-credit counter tells the upstream driver when a slot is guaranteed:
// can_issue_o = (occupancy + results still in flight) < DEPTH. Sticky
// exception flags accumulate for status readback.
// Configuration macro: FP32_RESBUF_NAN_CANON_EN
//   defined   : NaN results are stored as the canonical quiet NaN 7FC00000
//   undefined : NaN payloads pass through bit-exact
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   issue_i, can_issue_o  : upstream issue tap and issue permission
//   done_i, result_i      : adder completion and result
//   overflow_i, underflow_i, invalid_i : adder flags
//   valid_o, ready_i      : consumer handshake
//   data_o, flags_o       : head result and {invalid, overflow, underflow}
//   sticky_o, clear_i     : {lost, invalid, overflow, underflow} and clear
//   count_o               : FIFO occupancy
// -----------------------------------------------------------------------------
module fp32_add_result_buffer
  import fp32_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int ADDER_LATENCY = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_i,
  output logic                       can_issue_o,
  input  logic                       done_i,
  input  logic [31:0]                result_i,
  input  logic                       overflow_i,
  input  logic                       underflow_i,
  input  logic                       invalid_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [31:0]                data_o,
  output logic [2:0]                 flags_o,
  output logic [STICKY_W-1:0]        sticky_o,
  input  logic                       clear_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  // The credit scheme is latency-agnostic; the latency contributes nothing.
  localparam int CNT_W = $clog2(DEPTH+1) + (0 * ADDER_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   SUM_LIM  = (CNT_W+1)'(DEPTH);

  fp32_entry_t         push_entry_s;
  fp32_entry_t         head_s;
  logic                full_s;
  logic                empty_s;
  logic [CNT_W-1:0]    count_s;
  logic                pop_s;
  logic                accept_s;
  logic                lost_s;
  logic [CNT_W-1:0]    inflight_r;
  logic [CNT_W-1:0]    inflight_next_s;
  logic [CNT_W:0]      credit_sum_s;
  logic [STICKY_W-1:0] sticky_r;
  logic [STICKY_W-1:0] sticky_event_s;
  logic [STICKY_W-1:0] sticky_next_s;

  // Entry written at the tail, with optional NaN canonicalisation.
  always_comb begin
    push_entry_s                = '0;
`ifdef FP32_RESBUF_NAN_CANON_EN
    push_entry_s.result         = fp32_canon_nan(result_i);
`else
    push_entry_s.result         = result_i;
`endif
    push_entry_s.flags.invalid   = invalid_i;
    push_entry_s.flags.overflow  = overflow_i;
    push_entry_s.flags.underflow = underflow_i;
  end

  fp32_resbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (done_i),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign pop_s    = !empty_s && ready_i;
  assign accept_s = done_i && (!full_s || pop_s);
  assign lost_s   = done_i && full_s && !pop_s;

  // Next in-flight count: issue adds, done retires, both cancel out.
  always_comb begin
    inflight_next_s = inflight_r;
    case ({issue_i, done_i})
      2'b10: begin
        if (inflight_r != CNT_MAX) begin
          inflight_next_s = inflight_r + CNT_ONE;
        end else begin
          inflight_next_s = inflight_r;
        end
      end
      2'b01: begin
        // A stray done with nothing in flight is still buffered but not counted.
        if (inflight_r != CNT_ZERO) begin
          inflight_next_s = inflight_r - CNT_ONE;
        end else begin
          inflight_next_s = inflight_r;
        end
      end
      default: inflight_next_s = inflight_r;
    endcase
  end

  // In-flight credit register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_r <= CNT_ZERO;
    end else begin
      inflight_r <= inflight_next_s;
    end
  end

  // Credit is taken from registered state only, so ready_i never reaches it.
  assign credit_sum_s = {1'b0, count_s} + {1'b0, inflight_r};
  assign can_issue_o  = (credit_sum_s < SUM_LIM);

  // Sticky events this cycle; an event overrides a coincident clear.
  always_comb begin
    sticky_event_s                   = {STICKY_W{1'b0}};
    sticky_event_s[STICKY_LOST]      = lost_s;
    sticky_event_s[STICKY_INVALID]   = accept_s && invalid_i;
    sticky_event_s[STICKY_OVERFLOW]  = accept_s && overflow_i;
    sticky_event_s[STICKY_UNDERFLOW] = accept_s && underflow_i;
    if (clear_i) begin
      sticky_next_s = sticky_event_s;
    end else begin
      sticky_next_s = sticky_r | sticky_event_s;
    end
  end

  // Sticky status register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_r <= {STICKY_W{1'b0}};
    end else begin
      sticky_r <= sticky_next_s;
    end
  end

  assign valid_o  = !empty_s;
  assign data_o   = head_s.result;
  assign flags_o  = head_s.flags;
  assign sticky_o = sticky_r;
  assign count_o  = count_s;

endmodule
